// File: rtl/ram_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
// Combinational definitions only; no latency or flow control here.
package ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RD_LATENCY = 1;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset sweep that zeroes every RAM word, one address per cycle.
// init_done rises 2**ADDR_WIDTH cycles after reset release; not stallable.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done
);

  // One extra counter bit keeps the last-address compare free of wrap.
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);

  clr_state_t            state;
  logic [ADDR_WIDTH:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: begin
          init_done <= 1'b1;
        end
        default: begin
          state     <= CLEAR;
          cnt       <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = rst && (state == CLEAR);
  assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/dpram_be.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write and 1/2-cycle reads.
// Reads return RD_LATENCY cycles after acceptance at full rate; requests are ignored until init_done.
module dpram_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH/8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_act;
  logic                  rd_act;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat;

  ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  assign wr_act = init_done && wr_enb && (|wr_be);
  assign rd_act = init_done && rd_enb;

  always_comb begin
    wr_word = mem[wr_addr];
    for (int k = 0; k < LANES; k++) begin
      if (wr_be[k]) begin
        wr_word[8*k +: 8] = wr_data[8*k +: 8];
      end
    end
  end

  // New-data mode forwards the merged write word instead of the stored one.
  assign bypass  = (RDW_MODE == RDW_NEW) && wr_act && (wr_addr == rd_addr);
  assign rd_word = bypass ? wr_word : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_act) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Any RD_LATENCY other than 2 builds the single-register path.
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_vld <= 1'b0;
        s1_dat <= '0;
      end else begin
        s1_vld <= rd_act;
        if (rd_act) begin
          s1_dat <= rd_word;
        end
      end
    end

    assign pipe_vld = s1_vld;
    assign pipe_dat = s1_dat;
  end else begin : g_lat1
    assign pipe_vld = rd_act;
    assign pipe_dat = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pipe_vld;
      if (pipe_vld) begin
        rd_data <= pipe_dat;
      end
    end
  end

endmodule

// File: tb/tb_dpram_be.sv
// Drives three dpram_be variants (lat2/old, lat2/new, lat1/old) in lockstep
// and checks every cycle of their outputs against a scoreboard fed by a word model.
module tb_dpram_be;

  typedef struct {
    int          due;
    logic [15:0] dat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_enb = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_enb = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [15:0] rd_data [3];
  logic [2:0]  rd_valid;
  logic [2:0]  init_done;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  bit mon_en = 1'b0;
  bit ready = 1'b0;

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];
  logic [15:0] last [3];
  logic [15:0] mdl [16];

  dpram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(0)) u_old (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .init_done(init_done[0]));

  dpram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1)) u_new (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .init_done(init_done[1]));

  dpram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0)) u_l1 (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[2]),
    .rd_valid(rd_valid[2]), .init_done(init_done[2]));

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int due, input logic [15:0] dat);
    sb_t e;
    e.due = due;
    e.dat = dat;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id);
    sb_t e;
    bit  has;
    bit  exp_v;
    has = 1'b0;
    e.due = 0;
    e.dat = '0;
    case (id)
      0:       if (q0.size() > 0) begin has = 1'b1; e = q0[0]; end
      1:       if (q1.size() > 0) begin has = 1'b1; e = q1[0]; end
      default: if (q2.size() > 0) begin has = 1'b1; e = q2[0]; end
    endcase
    exp_v = has && (e.due == edge_cnt);
    chk($sformatf("rd_valid[%0d]@%0d", id, edge_cnt), {15'b0, rd_valid[id]}, {15'b0, exp_v});
    if (exp_v) begin
      case (id)
        0:       void'(q0.pop_front());
        1:       void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
      chk($sformatf("rd_data[%0d]@%0d", id, edge_cnt), rd_data[id], e.dat);
      last[id] = e.dat;
    end else begin
      chk($sformatf("rd_hold[%0d]@%0d", id, edge_cnt), rd_data[id], last[id]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_enb = 1'b0;
    wr_be  = '0;
    rd_enb = 1'b0;
  endtask

  // One cycle of stimulus; expectations come from the word model before it is updated.
  task automatic op(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                    input logic [1:0] be, input bit re, input logic [3:0] ra);
    logic [15:0] merged;
    logic [15:0] old_w;
    logic [15:0] new_w;
    wr_enb = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_enb = re; rd_addr = ra;
    merged = mdl[wa];
    if (be[0]) merged[7:0]  = wd[7:0];
    if (be[1]) merged[15:8] = wd[15:8];
    old_w = mdl[ra];
    new_w = (we && (be != 2'b00) && (wa == ra)) ? merged : old_w;
    if (ready && re) begin
      push(0, edge_cnt + 2, old_w);
      push(1, edge_cnt + 2, new_w);
      push(2, edge_cnt + 1, old_w);
    end
    if (ready && we) mdl[wa] = merged;
    tick();
    idle();
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    tick();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) last[i] = '0;
    ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid[%0d]", d), {15'b0, rd_valid[d]}, 16'h0);
      chk($sformatf("rst_data[%0d]", d), rd_data[d], 16'h0);
      chk($sformatf("rst_init[%0d]", d), {15'b0, init_done[d]}, 16'h0);
    end
  endtask

  // Release reset and watch init_done; a write and read are attempted in clear cycle 2.
  task automatic do_init();
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("init_done[%0d]@%0d", d, i), {15'b0, init_done[d]}, {15'b0, (i == 16)});
      end
      if (i == 1) begin
        wr_enb = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
        rd_enb = 1'b1; rd_addr = 4'd7;
      end else begin
        idle();
      end
    end
    for (int a = 0; a < 16; a++) mdl[a] = '0;
    ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) last[i] = '0;
    for (int a = 0; a < 16; a++) mdl[a] = '0;
    tick();
    tick();
    apply_reset();
    mon_en = 1'b1;
    do_init();

    // Every address reads zero after the sweep, back to back.
    for (int a = 0; a < 16; a++) op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));

    // Byte-lane merge, then a write with no lanes enabled.
    op(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0);
    op(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd3);
    op(1'b1, 4'd4, 16'hFFFF, 2'b00, 1'b0, 4'd0);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd4);

    // Same-address read during write, full and partial lanes.
    op(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0);
    op(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5);
    op(1'b1, 4'd5, 16'h33CC, 2'b01, 1'b1, 4'd5);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd5);

    // Different-address read and write in one cycle.
    op(1'b1, 4'd6, 16'h6666, 2'b11, 1'b1, 4'd5);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd6);

    // Distinct words at 0..2 read in three consecutive cycles.
    op(1'b1, 4'd0, 16'hC0DE, 2'b11, 1'b0, 4'd0);
    op(1'b1, 4'd1, 16'h0B0B, 2'b11, 1'b0, 4'd0);
    op(1'b1, 4'd2, 16'hFACE, 2'b10, 1'b0, 4'd0);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd0);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd1);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd2);

    // Write attempted during clear must not have landed.
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd7);
    repeat (4) tick();

    // Reset one cycle after a read is accepted, before the 2-cycle return.
    op(1'b1, 4'd9, 16'h00FF, 2'b11, 1'b0, 4'd0);
    op(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd9);
    apply_reset();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_valid[%0d]", d), {15'b0, rd_valid[d]}, 16'h0);
      chk($sformatf("post_rst_data[%0d]", d), rd_data[d], 16'h0);
    end
    do_init();
    op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9);
    op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    repeat (4) tick();

    chk("drain_q0", 16'(q0.size()), 16'h0);
    chk("drain_q1", 16'(q1.size()), 16'h0);
    chk("drain_q2", 16'(q2.size()), 16'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
